// File: rtl/lp_ser_word_feeder_if.sv
// Upstream valid/ready word stream feeding the serializer word feeder.
interface lp_ser_word_feeder_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   // Upstream source drives data/valid and observes ready.
   modport master (output data, output valid, input ready);
   // Feeder accepts data/valid and reports ready.
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/lp_ser_word_feeder.sv
// Word feeder for the 16:1 low-power tree serializer. Buffers upstream words
// in a small FIFO and presents one word on o_par_out per serializer word
// period, substituting idle or training patterns as required.
module lp_ser_word_feeder #(
   parameter int               WIDTH         = 16,
   parameter int               WORD_CYCLES   = 8,
   parameter int               DEPTH         = 4,
   parameter logic [WIDTH-1:0] IDLE_PATTERN  = 16'h0000,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = 16'hF0CA
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_enable,
   input  logic                     i_train,
   input  logic                     i_clr_underrun,
   lp_ser_word_feeder_if.slave      s_in,
   output logic [WIDTH-1:0]         o_par_out,
   output logic                     o_word_strobe,
   output logic [$clog2(DEPTH):0]   o_fifo_level,
   output logic [7:0]               o_underrun_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(WORD_CYCLES);
   localparam logic [PW-1:0] LAST_PHASE = PW'(WORD_CYCLES - 1);

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_TRAIN = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;

   logic [1:0]        r_rst_sync;
   logic              w_rst_n;

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [WIDTH-1:0]  w_head;

   logic [PW-1:0]     r_phase;
   logic              w_load;
   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic              w_train_load;
   logic              w_data_load;
   logic              w_underrun;

   logic [WIDTH-1:0]  r_par_out;
   logic              r_strobe;
   logic [7:0]        r_underrun_cnt;

   // Reset asserts immediately but releases two clocks later, synchronously.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   // FIFO flags; ready depends only on occupancy, so a full FIFO never takes a push.
   assign w_full     = (r_count == (AW+1)'(DEPTH));
   assign w_empty    = (r_count == '0);
   assign s_in.ready = !w_full;
   assign w_push     = s_in.valid && !w_full;
   assign w_head     = r_mem[r_rd_ptr];

   // A load event happens on the last cycle of each word period.
   assign w_load = i_enable && (r_phase == LAST_PHASE);

   // Next state: ENABLE low forces OFF at once; otherwise move only on loads.
   always_comb begin
      w_state_next = r_state;
      if (!i_enable) begin
         w_state_next = ST_OFF;
      end else if (w_load) begin
         case (r_state)
            ST_OFF, ST_TRAIN, ST_DATA: w_state_next = i_train ? ST_TRAIN : ST_DATA;
            default:                   w_state_next = ST_OFF;
         endcase
      end
   end

   // The load already follows the rules of the state being entered.
   assign w_train_load = w_load && (w_state_next == ST_TRAIN);
   assign w_data_load  = w_load && (w_state_next == ST_DATA);
   assign w_pop        = w_data_load && !w_empty;
   assign w_underrun   = w_data_load && w_empty;

   // FIFO storage; contents need no reset because pointers define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= s_in.data;
   end

   // FIFO pointers and occupancy; push and pop together leave the level unchanged.
   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
      end
   end

   // Phase counter wraps every word period and is parked at 0 while disabled.
   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n)      r_phase <= '0;
      else if (!i_enable || w_load) r_phase <= '0;
      else               r_phase <= r_phase + PW'(1);
   end

   // State register.
   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= ST_OFF;
      else          r_state <= w_state_next;
   end

   // Output word register; changes only on loads or when forced idle by ENABLE low.
   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_par_out <= IDLE_PATTERN;
         r_strobe  <= 1'b0;
      end else begin
         r_strobe <= w_load;
         if (!i_enable)         r_par_out <= IDLE_PATTERN;
         else if (w_train_load) r_par_out <= TRAIN_PATTERN;
         else if (w_pop)        r_par_out <= w_head;
         else if (w_underrun)   r_par_out <= IDLE_PATTERN;
      end
   end

   // Saturating underrun counter; a clear beats a coincident underrun.
   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n)                             r_underrun_cnt <= 8'd0;
      else if (i_clr_underrun)                  r_underrun_cnt <= 8'd0;
      else if (w_underrun && r_underrun_cnt != 8'hFF) r_underrun_cnt <= r_underrun_cnt + 8'd1;
   end

   assign o_par_out      = r_par_out;
   assign o_word_strobe  = r_strobe;
   assign o_fifo_level   = r_count;
   assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: doc/lp_ser_word_feeder.md
Name: lp_ser_word_feeder

Overview:
- Upstream feeder for the 16:1 low-power tree serializer. Accepts parallel words on a valid/ready stream and buffers them in a small FIFO.
- Drives PAR_OUT, which connects directly to the serializer's PAR_IN. PAR_OUT changes only on serializer word boundaries, exactly once every WORD_CYCLES clocks.
- Substitutes idle or training patterns when no data is available or training is requested.

Parameters:
- WIDTH, 16, parallel word width; must equal the serializer's INPUTS_NUM.
- WORD_CYCLES, 8, CLK cycles per serialized word (16 bits at 2 bits/CLK); legal range 2..256.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- IDLE_PATTERN, 16'h0000, word sent when the FIFO is empty or the block is disabled.
- TRAIN_PATTERN, 16'hF0CA, word sent repeatedly in TRAIN state.

Ports:
- CLK  in  1  serializer full-rate clock; the only clock.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  start word framing; low forces idle.
- TRAIN  in  1  request training pattern.
- IN_DATA  in  WIDTH  upstream word.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  FIFO can accept; equals !full (combinational from occupancy).
- PAR_OUT  out  WIDTH  registered word to the serializer PAR_IN.
- WORD_STROBE  out  1  one-cycle pulse, high in the first cycle a new PAR_OUT value is presented.
- FIFO_LEVEL  out  $clog2(DEPTH)+1  current occupancy.
- UNDERRUN_CNT  out  8  saturating count of data-state underruns.
- CLR_UNDERRUN  in  1  synchronous clear of UNDERRUN_CNT.

Behaviour:
- Reset (async assert, sync-safe deassert inside the block):
  - PAR_OUT=IDLE_PATTERN, WORD_STROBE=0, FIFO empty, FIFO_LEVEL=0, IN_READY=1.
  - UNDERRUN_CNT=0, phase counter=0, state=OFF.
- Push: IN_VALID && IN_READY writes IN_DATA to the FIFO tail. Data presented while IN_READY=0 is not taken and must be held by upstream.
- Phase counter:
  - Counts 0..WORD_CYCLES-1 and wraps while ENABLE=1.
  - Held at 0 while ENABLE=0.
  - The load event is counter==WORD_CYCLES-1.
- Load event: the next PAR_OUT is registered at that edge, and WORD_STROBE=1 for the following cycle. Latency from a load event to new PAR_OUT is 1 cycle.
- State machine (OFF, TRAIN, DATA); transitions are evaluated only at load events, except ENABLE=0:
  - OFF: PAR_OUT=IDLE_PATTERN. On the first load event with ENABLE=1, go to TRAIN if TRAIN=1, else DATA.
  - TRAIN: each load event loads TRAIN_PATTERN and leaves the FIFO untouched. If TRAIN=0 at a load event, go to DATA; that same load already uses DATA rules.
  - DATA: each load event pops the FIFO head into PAR_OUT. If the FIFO is empty, it loads IDLE_PATTERN and increments UNDERRUN_CNT (saturating at 255). If TRAIN=1 at a load event, go to TRAIN with no pop.
  - ENABLE falling in any state: next cycle go to OFF, PAR_OUT=IDLE_PATTERN, no WORD_STROBE, counter=0. FIFO contents are retained.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy unchanged; the pop returns the old head. A push into a full FIFO cannot occur, because ready is evaluated before the pop.
  - Empty FIFO with a push on the load cycle: no fall-through. Idle is sent, an underrun is counted, and the pushed word is sent at the next load.
  - CLR_UNDERRUN together with an underrun: the clear wins, so the count is 0.
- RESET_N asserted mid-word: all state returns to reset values immediately and FIFO contents are discarded.
- Between load events, PAR_OUT is stable. This is mandatory: the serializer latches PAR_IN bits on both CLK phases.

Test Plan:
- Reset, then ENABLE=1 and TRAIN=0 with no data -> PAR_OUT stays 16'h0000. WORD_STROBE pulses every 8 cycles, first at cycle 8 after ENABLE. UNDERRUN_CNT increments to 1, 2, 3...
- Push 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 back-to-back, then ENABLE=1 -> IN_READY low after the 4th push. PAR_OUT shows the words in order, one per 8 cycles, each stable for exactly 8 cycles. No underrun until the FIFO drains.
- TRAIN=1 during DATA with 2 words queued -> at the next load PAR_OUT=16'hF0CA and FIFO_LEVEL stays 2. After TRAIN=0, the queued words follow at the next load events.
- Push on the exact load cycle while the FIFO is empty -> that load sends IDLE and UNDERRUN_CNT+1. The next load sends the pushed word.
- ENABLE dropped mid-word with 3 words queued -> PAR_OUT=IDLE next cycle, no strobe, FIFO_LEVEL=3. After re-enable, the first word appears 8 cycles later.
- Underrun count driven to 255 then held, CLR_UNDERRUN coincident with an underrun -> 0. Async RESET_N pulse mid-word -> all outputs at reset values without a clock edge.
